// File: rtl/bisr_session_ctrl.sv
// Session-level BISR sequencer: STW self-test, per-column fault scan into a multi-spare repair map, matmul launch gating.
// Optional periodic re-test is compiled in with `define BISR_PERIODIC_TEST_EN.
module bisr_session_ctrl #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SPARES_PER_COL = 1,
  parameter int unsigned TEST_PERIOD    = 16,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned STW_TIMEOUT    = 1024
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               inputs_rdy,
  input  logic                                               fsm_rdy,
  input  logic                                               matmul_done,
  input  logic                                               stw_complete,
  input  logic [ROWS*COLS-1:0]                               stw_result_mat,
  output logic                                               stw_en,
  output logic                                               start_matmul,
  output logic [COLS*SPARES_PER_COL*($clog2(ROWS)+1)-1:0]    repair_map,
  output logic                                               repair_valid,
  output logic                                               unrepairable,
  output logic                                               stw_timeout,
  output logic [$clog2(ROWS*COLS+1)-1:0]                     fault_cnt,
  output logic [CNT_W-1:0]                                   matmul_cnt,
  output logic                                               busy
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned SW    = RW + 1;
  localparam int unsigned MAP_W = COLS * SPARES_PER_COL * SW;
  localparam int unsigned FW    = $clog2(ROWS*COLS+1);
  localparam int unsigned PW    = $clog2(ROWS+1);
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned TW    = $clog2(STW_TIMEOUT+1);

  typedef enum logic [2:0] {S_SELFTEST, S_SCAN, S_IDLE, S_RUN, S_FAULT} state_t;

  state_t                 state, state_d;
  logic [CW-1:0]          col, col_d;
  logic [TW-1:0]          tmo_cnt, tmo_cnt_d;
  logic [ROWS*COLS-1:0]   mat_q, mat_d;
  logic [MAP_W-1:0]       map_d, scan_map;
  logic [FW-1:0]          fcnt_d;
  logic [CNT_W-1:0]       mcnt_d;
  logic                   unrep_d, tmo_flag_d, start_d, stw_en_d, busy_d, rv_d;
  logic [ROWS-1:0]        col_bits;
  logic [PW-1:0]          col_pop;
  int unsigned            fill;

`ifdef BISR_PERIODIC_TEST_EN
  localparam int unsigned PERW = $clog2(TEST_PERIOD+1);
  logic [PERW-1:0] period_cnt, period_d, period_inc;
  assign period_inc = period_cnt + 1'b1;
`endif

  // Column selected by the scan pointer: its fault bits, popcount and slot assignment
  always_comb begin
    col_bits = '0;
    col_pop  = '0;
    scan_map = repair_map;
    fill     = 0;
    for (int c = 0; c < COLS; c++) begin
      if (CW'(c) == col) col_bits = mat_q[c*ROWS +: ROWS];
    end
    for (int r = 0; r < ROWS; r++) col_pop = col_pop + PW'(col_bits[r]);
    for (int c = 0; c < COLS; c++) begin
      if (CW'(c) == col) begin
        for (int r = 0; r < ROWS; r++) begin
          if (col_bits[r] && (fill < SPARES_PER_COL)) begin
            scan_map[(c*SPARES_PER_COL + fill)*SW +: SW] = {1'b1, RW'(r)};
            fill = fill + 1;
          end
        end
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    col_d      = col;
    tmo_cnt_d  = tmo_cnt;
    mat_d      = mat_q;
    map_d      = repair_map;
    fcnt_d     = fault_cnt;
    unrep_d    = unrepairable;
    tmo_flag_d = stw_timeout;
    mcnt_d     = matmul_cnt;
    start_d    = 1'b0;
`ifdef BISR_PERIODIC_TEST_EN
    period_d   = period_cnt;
`endif
    case (state)
      S_SELFTEST: begin
        if (stw_complete) begin
          mat_d   = stw_result_mat;
          map_d   = '0;
          fcnt_d  = '0;
          col_d   = '0;
          state_d = S_SCAN;
        end else if (tmo_cnt == TW'(STW_TIMEOUT-1)) begin
          tmo_flag_d = 1'b1;
          state_d    = S_FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      S_SCAN: begin
        map_d  = scan_map;
        fcnt_d = fault_cnt + FW'(col_pop);
        if (32'(col_pop) > SPARES_PER_COL) unrep_d = 1'b1;
        if (col == CW'(COLS-1)) state_d = unrep_d ? S_FAULT : S_IDLE;
        else                    col_d   = col + 1'b1;
      end
      S_IDLE: begin
        if (inputs_rdy && fsm_rdy) begin
          start_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (matmul_done) begin
          if (matmul_cnt != '1) mcnt_d = matmul_cnt + 1'b1;
          state_d = S_IDLE;
`ifdef BISR_PERIODIC_TEST_EN
          period_d = period_inc;
          if (period_inc == PERW'(TEST_PERIOD)) begin
            state_d   = S_SELFTEST;
            period_d  = '0;
            tmo_cnt_d = '0;
          end
`endif
        end
      end
      default: state_d = S_FAULT;
    endcase
    stw_en_d = (state_d == S_SELFTEST);
    busy_d   = (state_d inside {S_SELFTEST, S_SCAN, S_RUN});
    // Map is only advertised once a full scan has passed and until the next self-test
    rv_d     = (state_d inside {S_IDLE, S_RUN});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_SELFTEST;
      col          <= '0;
      tmo_cnt      <= '0;
      mat_q        <= '0;
      repair_map   <= '0;
      fault_cnt    <= '0;
      unrepairable <= 1'b0;
      stw_timeout  <= 1'b0;
      matmul_cnt   <= '0;
      start_matmul <= 1'b0;
      stw_en       <= 1'b0;
      busy         <= 1'b0;
      repair_valid <= 1'b0;
    end else begin
      state        <= state_d;
      col          <= col_d;
      tmo_cnt      <= tmo_cnt_d;
      mat_q        <= mat_d;
      repair_map   <= map_d;
      fault_cnt    <= fcnt_d;
      unrepairable <= unrep_d;
      stw_timeout  <= tmo_flag_d;
      matmul_cnt   <= mcnt_d;
      start_matmul <= start_d;
      stw_en       <= stw_en_d;
      busy         <= busy_d;
      repair_valid <= rv_d;
    end
  end

`ifdef BISR_PERIODIC_TEST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_cnt <= '0;
    else        period_cnt <= period_d;
  end
`endif

endmodule

// File: doc/bisr_session_ctrl.md
# bisr_session_ctrl

Session-level BISR sequencer placed above the matmul FSM and the weight-proxy systolic array. It runs a stop-the-world (STW) self-test after reset and then scans the per-PE fault matrix column by column. From that scan it builds a repair map that assigns faulty PEs to up to `SPARES_PER_COL` proxy slots per column, then gates matmul launches on a valid map. This generalises the single-proxy, boot-only BISR flow: it supports multiple spares per column, STW timeout detection, unrepairable-fault latching and, optionally, periodic re-test.

## Interface
Parameters:
- `ROWS`, default 4: PE rows.
- `COLS`, default 4: PE columns.
- `SPARES_PER_COL`, default 1: proxy slots per column, 1..ROWS.
- `TEST_PERIOD`, default 16: matmuls between periodic re-tests. Used only with the macro.
- `CNT_W`, default 8: width of `matmul_cnt`.
- `STW_TIMEOUT`, default 1024: cycles allowed for `stw_complete` to arrive.

Ports (`RW` = $clog2(ROWS)):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `inputs_rdy`  in  1  operand matrices are in memory.
- `fsm_rdy`  in  1  matmul FSM is idle and accepts `start_matmul`.
- `matmul_done`  in  1  one-cycle pulse when the output write-back completes.
- `stw_complete`  in  1  STW finished; `stw_result_mat` is valid while this is high.
- `stw_result_mat`  in  ROWS*COLS  bit `c*ROWS+r` = 1 means PE(r,c) is faulty.
- `stw_en`  out  1  level; requests STW from the array.
- `start_matmul`  out  1  one-cycle launch pulse.
- `repair_map`  out  COLS*SPARES_PER_COL*(RW+1)  slot `(c*SPARES_PER_COL+s)` = {valid, row}.
- `repair_valid`  out  1  `repair_map` is current and may be consumed by the proxies.
- `unrepairable`  out  1  sticky; some column has more than `SPARES_PER_COL` faults.
- `stw_timeout`  out  1  sticky; STW did not complete in time.
- `fault_cnt`  out  $clog2(ROWS*COLS+1)  total faulty PEs from the last scan.
- `matmul_cnt`  out  CNT_W  completed matmuls, saturating.
- `busy`  out  1  high in SELFTEST, SCAN and RUN.

## Operation
States: SELFTEST, SCAN, IDLE, RUN, FAULT.

- **Reset:** state = SELFTEST. All outputs are 0, `repair_map` is all 0 and all counters are 0.
- **SELFTEST:**
  - `stw_en` = 1 and `busy` = 1.
  - On `stw_complete`: latch `stw_result_mat` into an internal register, clear `repair_map` and `fault_cnt`, go to SCAN.
  - If the timeout counter reaches `STW_TIMEOUT` first: set `stw_timeout`, go to FAULT.
- **SCAN:**
  - Takes one cycle per column, c = 0..COLS-1.
  - Faulty rows of column c fill slots s = 0.. in ascending row order; each filled slot gets valid = 1.
  - `fault_cnt` is incremented by the popcount of column c.
  - If the popcount exceeds `SPARES_PER_COL`: set `unrepairable`. Scanning still completes so that `fault_cnt` is full.
  - After column COLS-1: go to FAULT if `unrepairable` is set, otherwise set `repair_valid` = 1 and go to IDLE.
- **IDLE:** when `inputs_rdy && fsm_rdy`, pulse `start_matmul` for one cycle and go to RUN.
- **RUN:**
  - Wait for `matmul_done`.
  - On `matmul_done`: increment `matmul_cnt`, saturating at 2^CNT_W-1, and increment the internal period counter.
  - Then go to IDLE, or to SELFTEST when the macro is on and the period counter equals `TEST_PERIOD`.
- **FAULT:** terminal. `busy` = 0, `repair_valid` = 0, `start_matmul` is never pulsed. Only `rst_n` exits.
- `repair_valid` drops to 0 on entry to SELFTEST and stays 0 through SCAN, so proxies never use a stale map.
- `stw_complete` outside SELFTEST is ignored. `matmul_done` outside RUN is ignored.

## Timing
- Cycle 0 after `rst_n` rises: state SELFTEST, `stw_en` registered high on that edge.
- `stw_complete` sampled at edge T: SCAN spans T+1..T+COLS. `repair_valid` = 1 from T+COLS+1.
- `start_matmul` is high exactly one cycle: the cycle after IDLE sees `inputs_rdy && fsm_rdy`.
- `matmul_done` at edge T:
  - `matmul_cnt` is updated at T+1, and the state is IDLE at T+1.
  - For a periodic re-test, the state is SELFTEST at T+1.
- The timeout counter is cleared on SELFTEST entry. `stw_timeout` is set on the edge where count == `STW_TIMEOUT`-1 without `stw_complete`.
- If `stw_complete` and the timeout occur on the same edge, `stw_complete` wins.
- `rst_n` low at any point, including mid-SCAN or mid-RUN: all state clears asynchronously and no `start_matmul` is emitted.

## Configuration
- `BISR_PERIODIC_TEST_EN` defined: after every `TEST_PERIOD` completed matmuls the block re-enters SELFTEST, then rebuilds the map; the period counter clears on SELFTEST entry.
- Undefined: STW runs only once after reset. The period counter and its compare logic are not generated.

## Test plan
- Fault-free: reset, `stw_complete` with matrix 0 → `repair_valid` = 1 after 4 SCAN cycles, `fault_cnt` = 0, all slots invalid.
- Repairable: ROWS=COLS=4, SPARES_PER_COL=2, faults at (1,0), (3,0), (2,2) → col0 slots {1,1},{1,3}; col2 slot0 {1,2}; `fault_cnt` = 3; `unrepairable` = 0.
- Unrepairable: SPARES_PER_COL=1, faults at (0,1) and (2,1) → `unrepairable` = 1, `fault_cnt` = 2, state FAULT, `inputs_rdy`/`fsm_rdy` held high produce no `start_matmul`.
- Timeout: STW_TIMEOUT=8, `stw_complete` never asserted → `stw_timeout` = 1 on the 8th cycle, `busy` = 0.
- Launch and periodic re-test: macro on, TEST_PERIOD=2, two `start_matmul`/`matmul_done` rounds → `matmul_cnt` = 2, then `stw_en` = 1 and `repair_valid` = 0 the next cycle. Macro off → IDLE instead.
- Async reset mid-SCAN (column 2): `rst_n` low → `repair_map` = 0, `fault_cnt` = 0, `stw_en` = 0 immediately, without waiting for a clock edge.
